// File: rtl/rec_calc_seq.sv
// rec_calc_seq: command sequencer for the rec_calc accumulator.
// Commands {clr, op, val, hold} are queued in a small FIFO. They are replayed one at a time onto
// calc_valA/calc_op/calc_reset. The accumulator result is returned on a valid/ready response port.
// Optional feature macro: REC_CALC_SEQ_CYCLES_EN adds rsp_cycles, which counts cycles per command.

module rec_calc_seq #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned OPW   = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLDW = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clr,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_val,
    input  logic [HOLDW-1:0] cmd_hold,
    output logic [WIDTH-1:0] calc_valA,
    output logic [OPW-1:0]   calc_op,
    output logic             calc_reset,
    input  logic [WIDTH-1:0] calc_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy
`ifdef REC_CALC_SEQ_CYCLES_EN
    ,
    output logic [15:0]      rsp_cycles
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 1 + OPW + WIDTH + HOLDW;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StDrive,
        StCapture,
        StResp
    } state_e;

    state_e             r_state;
    state_e             w_state_d;

    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;

    logic [OPW-1:0]     r_op;
    logic [WIDTH-1:0]   r_val;
    logic [HOLDW-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rsp_result;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [EW-1:0]      w_head;
    logic               w_head_clr;
    logic [OPW-1:0]     w_head_op;
    logic [WIDTH-1:0]   w_head_val;
    logic [HOLDW-1:0]   w_head_hold;

    logic [WIDTH-1:0]   w_valA;
    logic [OPW-1:0]     w_op;
    logic               w_clr_pulse;
    logic               w_rsp_valid;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = cmd_valid && !w_full;
    assign w_pop   = (r_state == StIdle) && !w_empty;

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];
    assign {w_head_clr, w_head_op, w_head_val, w_head_hold} = w_head;

    // Command storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {cmd_clr, cmd_op, cmd_val, cmd_hold};
        end
    end

    // Next-state and per-state bus drive.
    always_comb begin
        w_state_d   = r_state;
        w_valA      = '0;
        w_op        = '0;
        w_clr_pulse = 1'b0;
        w_rsp_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_d = w_head_clr ? StClr : StDrive;
                end
            end
            StClr: begin
                w_clr_pulse = 1'b1;
                w_state_d   = StDrive;
            end
            StDrive: begin
                w_valA = r_val;
                w_op   = r_op;
                if (r_cnt == '0) begin
                    w_state_d = StCapture;
                end
            end
            StCapture: begin
                // Operand stays on the bus while the registered result settles.
                w_valA    = r_val;
                w_op      = r_op;
                w_state_d = StResp;
            end
            StResp: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM state, FIFO pointers, working command and response capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_op         <= '0;
            r_val        <= '0;
            r_cnt        <= '0;
            r_rsp_result <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_op     <= w_head_op;
                r_val    <= w_head_val;
                r_cnt    <= w_head_hold;
            end
            if ((r_state == StDrive) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == StCapture) begin
                r_rsp_result <= calc_result;
            end
        end
    end

`ifdef REC_CALC_SEQ_CYCLES_EN
    logic [15:0] r_cycles;

    // Cycles from the pop cycle through CAPTURE inclusive, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= '0;
        end else if (w_pop) begin
            r_cycles <= 16'd1;
        end else if (((r_state == StClr) || (r_state == StDrive) || (r_state == StCapture)) &&
                     (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign rsp_cycles = r_cycles;
`endif

    // rec_calc is held in reset for as long as this block is.
    assign calc_reset = !reset_n || w_clr_pulse;
    assign calc_valA  = w_valA;
    assign calc_op    = w_op;
    assign rsp_valid  = w_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign cmd_ready  = !w_full;
    assign busy       = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_rec_calc_seq.sv
// Bench for rec_calc_seq with a behavioural accumulator standing in for rec_calc.
module tb_rec_calc_seq;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_clr;
    logic [3:0]  cmd_op;
    logic [16:0] cmd_val;
    logic [7:0]  cmd_hold;
    logic [16:0] calc_valA;
    logic [3:0]  calc_op;
    logic        calc_reset;
    logic [16:0] calc_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [16:0] rsp_result;
    logic        busy;

    logic [16:0] m_res;
    logic [16:0] exp_q [$];
    logic [16:0] sb_acc;
    logic        rnd_ready;
    logic        stall_prev;
    logic [16:0] prev_res;
    int          total;
    int          bad;

    rec_calc_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_clr     (cmd_clr),
        .cmd_op      (cmd_op),
        .cmd_val     (cmd_val),
        .cmd_hold    (cmd_hold),
        .calc_valA   (calc_valA),
        .calc_op     (calc_op),
        .calc_reset  (calc_reset),
        .calc_result (calc_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in accumulator: 0 add, 1 sub, 2 xor, others hold.
    function automatic logic [16:0] calc_apply(input logic [3:0] op, input logic [16:0] a,
                                               input logic [16:0] v);
        case (op)
            4'd0:    return a + v;
            4'd1:    return a - v;
            4'd2:    return a ^ v;
            default: return a;
        endcase
    endfunction

    // Registered result, one cycle after the operands.
    always_ff @(posedge clk) begin
        if (calc_reset) m_res <= '0;
        else            m_res <= calc_apply(calc_op, m_res, calc_valA);
    end
    assign calc_result = m_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard, sampled at the falling edge.
    task automatic mon();
        logic [16:0] e;
        if (!reset_n) begin
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev) begin
            chk("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_hold_result", {15'd0, rsp_result}, {15'd0, prev_res});
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_result", {15'd0, rsp_result}, {15'd0, e});
            end
        end
        stall_prev = rsp_valid && !rsp_ready;
        prev_res   = rsp_result;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // Offer one command, push its expected response once accepted.
    task automatic send(input logic clr, input logic [3:0] op, input logic [16:0] val,
                        input logic [7:0] hold);
        int b;
        b = 0;
        cmd_valid = 1'b1;
        cmd_clr   = clr;
        cmd_op    = op;
        cmd_val   = val;
        cmd_hold  = hold;
        while (!cmd_ready && b < 2000) begin
            step();
            b++;
        end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        if (clr) sb_acc = '0;
        for (int i = 0; i <= int'(hold); i++) sb_acc = calc_apply(op, sb_acc, val);
        exp_q.push_back(sb_acc);
        // The capture cycle keeps the operand on the bus, so the accumulator sees it once more.
        sb_acc = calc_apply(op, sb_acc, val);
        step();
        cmd_valid = 1'b0;
    endtask

    // Single command with bus timing checks; rsp_ready held low until the response shows.
    task automatic run_one(input logic clr, input logic [3:0] op, input logic [16:0] val,
                           input logic [7:0] hold);
        int nrst;
        int nval;
        int lat;
        nrst = 0;
        nval = 0;
        lat  = 0;
        rsp_ready = 1'b0;
        send(clr, op, val, hold);
        while (!rsp_valid && lat < 600) begin
            if (calc_reset) nrst++;
            if (calc_valA == val) nval++;
            step();
            lat++;
        end
        chk("rsp_latency", lat, 32'(int'(clr) + int'(hold) + 3));
        chk("clr_pulse_cycles", nrst, {31'd0, clr});
        chk("valA_drive_cycles", nval, 32'(int'(hold) + 2));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("idle_after_rsp", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int b;
        int n;
        total      = 0;
        bad        = 0;
        sb_acc     = '0;
        rnd_ready  = 1'b0;
        stall_prev = 1'b0;
        prev_res   = '0;
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_clr    = 1'b0;
        cmd_op     = '0;
        cmd_val    = '0;
        cmd_hold   = '0;
        rsp_ready  = 1'b0;

        // Reset held three cycles.
        repeat (3) step();
        chk("rst_calc_reset", {31'd0, calc_reset}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valA", {15'd0, calc_valA}, 32'd0);
        chk("rst_rsp_result", {15'd0, rsp_result}, 32'd0);
        reset_n = 1'b1;
        step();
        chk("post_rst_calc_reset", {31'd0, calc_reset}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Directed single commands, including the longest hold.
        run_one(1'b1, 4'd0, 17'd1, 8'd0);
        run_one(1'b0, 4'd0, 17'd2, 8'd3);
        run_one(1'b0, 4'd1, 17'd7, 8'd1);
        run_one(1'b1, 4'd2, 17'h1_5A5A, 8'd2);
        run_one(1'b0, 4'd0, 17'd1, 8'd255);

        // Five back-to-back commands with responses blocked: one popped, four fill the FIFO.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b0, 4'd0, 17'(i + 1), 8'd0);
        chk("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("fifo_full_busy", {31'd0, busy}, 32'd1);
        cmd_valid = 1'b1;
        cmd_val   = 17'd99;
        repeat (3) step();
        chk("fifo_full_stays", {31'd0, cmd_ready}, 32'd0);
        chk("rsp_blocked_valid", {31'd0, rsp_valid}, 32'd1);
        cmd_valid = 1'b0;
        rnd_ready = 1'b1;
        b = 0;
        while (exp_q.size() != 0 && b < 500) begin
            step();
            b++;
        end
        chk("drain_fill", exp_q.size(), 32'd0);

        // Random commands against a randomly stalling consumer.
        for (int i = 0; i < 10; i++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 17'($urandom),
                 8'($urandom_range(0, 5)));
        end
        b = 0;
        while (exp_q.size() != 0 && b < 1000) begin
            step();
            b++;
        end
        chk("drain_random", exp_q.size(), 32'd0);
        rnd_ready = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) step();
        chk("idle_after_random", {31'd0, busy}, 32'd0);

        // Reset in the middle of a long drive.
        rsp_ready = 1'b1;
        send(1'b0, 4'd0, 17'd5, 8'd10);
        b = 0;
        while (calc_valA != 17'd5 && b < 50) begin
            step();
            b++;
        end
        chk("drive_seen", {15'd0, calc_valA}, 32'd5);
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        chk("abort_valA", {15'd0, calc_valA}, 32'd0);
        chk("abort_op", {28'd0, calc_op}, 32'd0);
        chk("abort_calc_reset", {31'd0, calc_reset}, 32'd1);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        sb_acc = '0;
        repeat (2) step();
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) n++;
            step();
        end
        chk("abort_no_replay", n, 32'd0);
        chk("abort_fifo_empty", {31'd0, busy}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        run_one(1'b0, 4'd1, 17'd3, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
